// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the memory bus arbiter: requester IDs and the lock-state encoding.
package mem_bus_arbiter_pkg;

    localparam logic OWNER_IRAM = 1'b0;
    localparam logic OWNER_DRAM = 1'b1;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LOCK_I   = 2'd1,
        LOCK_D   = 2'd2
    } lock_state_e;

    function automatic lock_state_e lock_for(input logic owner);
        return (owner == OWNER_DRAM) ? LOCK_D : LOCK_I;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_arb_id_fifo.sv
// Ordered record of which requester owns each outstanding read.
// Pointers carry one extra wrap bit so that full and empty can be told apart.
module arb_id_fifo
    import mem_bus_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic din,
    input  logic pop,
    output logic full,
    output logic empty,
    output logic dout
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic          mem [0:(1 << AW) - 1];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [AW:0]   used;

    assign used  = wr_ptr - rd_ptr;
    assign full  = (used == (AW + 1)'(DEPTH));
    assign empty = (used == '0);
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory bus between the instruction fetch port and the data port, and
// routes each in-order read response back to the port that issued the read.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int XLEN            = 32,
    parameter int MAX_OUTSTANDING = 2,
    parameter int STARVE_LIMIT    = 4,
    parameter bit DRAM_PRIORITY   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              iram_req,
    input  logic [XLEN-1:0]   iram_addr,
    output logic              iram_ready,
    output logic              iram_rvalid,
    output logic [XLEN-1:0]   iram_rdata,
    input  logic              dram_req,
    input  logic              dram_write,
    input  logic [XLEN/8-1:0] dram_wstrb,
    input  logic [XLEN-1:0]   dram_addr,
    input  logic [XLEN-1:0]   dram_wdata,
    output logic              dram_ready,
    output logic              dram_rvalid,
    output logic [XLEN-1:0]   dram_rdata,
    output logic              bus_req,
    output logic              bus_write,
    output logic [XLEN/8-1:0] bus_wstrb,
    output logic [XLEN-1:0]   bus_addr,
    output logic [XLEN-1:0]   bus_wdata,
    input  logic              bus_ready,
    input  logic              bus_rvalid,
    input  logic [XLEN-1:0]   bus_rdata,
    output logic              arb_err
);

    localparam int            SW            = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX    = SW'(STARVE_LIMIT);
    localparam logic          DEFAULT_OWNER = DRAM_PRIORITY ? OWNER_DRAM : OWNER_IRAM;

    lock_state_e   lock_state;
    lock_state_e   lock_next;
    logic [SW-1:0] starve_cnt;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_dout;
    logic          iram_elig;
    logic          dram_elig;
    logic          want_bus;
    logic          grant;
    logic          accept;
    logic          push;
    logic          pop;
    logic          nd_req;
    logic          nd_elig;
    logic          nd_accept;

    // A locked grant is held without re-checking eligibility until the bus accepts.
    always_comb begin
        iram_elig = iram_req & ~fifo_full;
        dram_elig = dram_req & (dram_write | ~fifo_full);
        grant     = DEFAULT_OWNER;
        want_bus  = 1'b0;
        lock_next = lock_state;
        case (lock_state)
            LOCK_I: begin
                grant    = OWNER_IRAM;
                want_bus = 1'b1;
            end
            LOCK_D: begin
                grant    = OWNER_DRAM;
                want_bus = 1'b1;
            end
            default: begin
                want_bus = iram_elig | dram_elig;
                if (iram_elig && dram_elig) begin
                    grant = (starve_cnt == STARVE_MAX) ? ~DEFAULT_OWNER : DEFAULT_OWNER;
                end else if (dram_elig) begin
                    grant = OWNER_DRAM;
                end else begin
                    grant = OWNER_IRAM;
                end
            end
        endcase
        if (want_bus) begin
            lock_next = bus_ready ? UNLOCKED : lock_for(grant);
        end
    end

    assign bus_req    = want_bus & ~rst;
    assign accept     = bus_req & bus_ready;
    assign iram_ready = accept & (grant == OWNER_IRAM);
    assign dram_ready = accept & (grant == OWNER_DRAM);

    assign bus_write = (grant == OWNER_DRAM) & dram_write;
    assign bus_wstrb = (grant == OWNER_DRAM) ? dram_wstrb : '0;
    assign bus_addr  = (grant == OWNER_DRAM) ? dram_addr  : iram_addr;
    assign bus_wdata = (grant == OWNER_DRAM) ? dram_wdata : '0;

    // Writes never produce a response, so only read accepts are recorded.
    assign push = accept & ~bus_write;
    assign pop  = bus_rvalid & ~fifo_empty & ~rst;

    assign iram_rvalid = pop & (fifo_dout == OWNER_IRAM);
    assign dram_rvalid = pop & (fifo_dout == OWNER_DRAM);
    assign iram_rdata  = bus_rdata;
    assign dram_rdata  = bus_rdata;

    arb_id_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (grant),
        .pop   (pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .dout  (fifo_dout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_state <= UNLOCKED;
        end else begin
            lock_state <= lock_next;
        end
    end

    assign nd_req    = DRAM_PRIORITY ? iram_req  : dram_req;
    assign nd_elig   = DRAM_PRIORITY ? iram_elig : dram_elig;
    assign nd_accept = accept & (grant == ~DEFAULT_OWNER);

    // Counts how long the non-default port has been kept waiting while it could have gone.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (nd_accept || !nd_req) begin
            starve_cnt <= '0;
        end else if (nd_elig && starve_cnt != STARVE_MAX) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            arb_err <= 1'b0;
        end else if (bus_rvalid && fifo_empty) begin
            arb_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed scenarios followed by randomized traffic, all checked against a queue-based
// model of the arbitration, starvation and in-order response routing rules.
module tb_mem_bus_arbiter;

    localparam int XLEN  = 32;
    localparam int MAXO  = 2;
    localparam int LIMIT = 4;
    localparam bit DPRI  = 1'b1;

    logic              clk = 1'b0;
    logic              rst;
    logic              iram_req;
    logic [XLEN-1:0]   iram_addr;
    logic              iram_ready;
    logic              iram_rvalid;
    logic [XLEN-1:0]   iram_rdata;
    logic              dram_req;
    logic              dram_write;
    logic [XLEN/8-1:0] dram_wstrb;
    logic [XLEN-1:0]   dram_addr;
    logic [XLEN-1:0]   dram_wdata;
    logic              dram_ready;
    logic              dram_rvalid;
    logic [XLEN-1:0]   dram_rdata;
    logic              bus_req;
    logic              bus_write;
    logic [XLEN/8-1:0] bus_wstrb;
    logic [XLEN-1:0]   bus_addr;
    logic [XLEN-1:0]   bus_wdata;
    logic              bus_ready;
    logic              bus_rvalid;
    logic [XLEN-1:0]   bus_rdata;
    logic              arb_err;

    int checks = 0;
    int errors = 0;

    // Model state: port holding a locked grant (-1 none), starvation count,
    // owners of outstanding reads in issue order, sticky error.
    int held   = -1;
    int starve = 0;
    bit owners[$];
    bit err    = 1'b0;
    bit last_acc;
    bit last_win;

    always #5 clk = ~clk;

    mem_bus_arbiter #(
        .XLEN            (XLEN),
        .MAX_OUTSTANDING (MAXO),
        .STARVE_LIMIT    (LIMIT),
        .DRAM_PRIORITY   (DPRI)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .iram_req    (iram_req),
        .iram_addr   (iram_addr),
        .iram_ready  (iram_ready),
        .iram_rvalid (iram_rvalid),
        .iram_rdata  (iram_rdata),
        .dram_req    (dram_req),
        .dram_write  (dram_write),
        .dram_wstrb  (dram_wstrb),
        .dram_addr   (dram_addr),
        .dram_wdata  (dram_wdata),
        .dram_ready  (dram_ready),
        .dram_rvalid (dram_rvalid),
        .dram_rdata  (dram_rdata),
        .bus_req     (bus_req),
        .bus_write   (bus_write),
        .bus_wstrb   (bus_wstrb),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_ready   (bus_ready),
        .bus_rvalid  (bus_rvalid),
        .bus_rdata   (bus_rdata),
        .arb_err     (arb_err)
    );

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input bit ir, input logic [31:0] ia, input bit dr, input bit dw,
                                  input logic [31:0] da, input logic [31:0] wd, input logic [3:0] ws,
                                  input bit br, input bit rv, input logic [31:0] rd);
        iram_req   = ir;
        iram_addr  = ia;
        dram_req   = dr;
        dram_write = dw;
        dram_addr  = da;
        dram_wdata = wd;
        dram_wstrb = ws;
        bus_ready  = br;
        bus_rvalid = rv;
        bus_rdata  = rd;
    endtask

    task automatic idle(input bit rv, input logic [31:0] rd);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, rv, rd);
    endtask

    // One clock cycle: compare every output against the model, then advance the model
    // across the rising edge. Entered and left just after a falling edge.
    task automatic cycle();
        bit full, ie, de, req, win, acc, iv, dv, nd, nd_req, nd_elig;
        #1;
        full = (owners.size() >= MAXO);
        ie   = iram_req && !full;
        de   = dram_req && (dram_write || !full);
        win  = 1'b0;
        req  = 1'b0;
        if (rst) begin
            req = 1'b0;
        end else if (held >= 0) begin
            req = 1'b1;
            win = (held == 1);
        end else begin
            req = ie || de;
            if (ie && de) win = (starve == LIMIT) ? !DPRI : DPRI;
            else          win = de;
        end
        acc = req && bus_ready;
        check_output("bus_req", bus_req, req);
        check_output("iram_ready", iram_ready, acc && !win);
        check_output("dram_ready", dram_ready, acc && win);
        if (req) begin
            check_output("bus_addr", bus_addr, win ? dram_addr : iram_addr);
            check_output("bus_write", bus_write, win && dram_write);
            if (win && dram_write) begin
                check_output("bus_wdata", bus_wdata, dram_wdata);
                check_output("bus_wstrb", bus_wstrb, dram_wstrb);
            end
        end
        iv = 1'b0;
        dv = 1'b0;
        if (!rst && bus_rvalid && owners.size() > 0) begin
            if (owners[0]) begin
                dv = 1'b1;
                check_output("dram_rdata", dram_rdata, bus_rdata);
            end else begin
                iv = 1'b1;
                check_output("iram_rdata", iram_rdata, bus_rdata);
            end
        end
        check_output("iram_rvalid", iram_rvalid, iv);
        check_output("dram_rvalid", dram_rvalid, dv);
        check_output("arb_err", arb_err, err);
        last_acc = acc;
        last_win = win;
        @(posedge clk);
        if (rst) begin
            held   = -1;
            starve = 0;
            owners.delete();
            err    = 1'b0;
        end else begin
            if (bus_rvalid) begin
                if (owners.size() > 0) void'(owners.pop_front());
                else err = 1'b1;
            end
            if (acc && !(win && dram_write)) owners.push_back(win);
            nd      = !DPRI;
            nd_req  = nd ? dram_req : iram_req;
            nd_elig = nd ? de : ie;
            if ((acc && win == nd) || !nd_req) starve = 0;
            else if (nd_elig && starve < LIMIT) starve++;
            if (req) held = bus_ready ? -1 : int'(win);
        end
        @(negedge clk);
    endtask

    initial begin
        bit          ipend;
        bit          dpend;
        logic [31:0] ia, da, wd;
        logic [3:0]  ws;
        bit          dw;

        rst = 1'b1;
        idle(0, 0);
        @(negedge clk);
        cycle();
        rst = 1'b0;

        // Idle after reset.
        #1;
        check_output("reset_bus_req", bus_req, 1'b0);
        check_output("reset_arb_err", arb_err, 1'b0);
        cycle();

        // Single fetch accepted in the same cycle, response two cycles later.
        apply_stimulus(1, 32'h100, 0, 0, 0, 0, 0, 1, 0, 0);
        #1;
        check_output("fetch_ready", iram_ready, 1'b1);
        check_output("fetch_addr", bus_addr, 32'h100);
        cycle();
        idle(0, 0);
        cycle();
        idle(1, 32'hDEAD);
        #1;
        check_output("fetch_rvalid", iram_rvalid, 1'b1);
        check_output("fetch_rdata", iram_rdata, 32'hDEAD);
        check_output("fetch_no_dram", dram_rvalid, 1'b0);
        cycle();

        // Both reading every cycle: dram wins four times, iram the fifth, then dram again.
        for (int k = 0; k < 6; k++) begin
            apply_stimulus(1, 32'h400 + k, 1, 0, 32'h800 + k, 0, 0, 1, k > 0, 32'h5000 + k);
            #1;
            check_output("starve_dram_ready", dram_ready, k != 4);
            check_output("starve_iram_ready", iram_ready, k == 4);
            cycle();
        end
        idle(1, 32'h5555);
        cycle();

        // Store stalled by the bus: grant stays with dram while iram waits.
        for (int k = 0; k < 4; k++) begin
            apply_stimulus(k > 0, 32'h104, 1, 1, 32'h200, 32'h12345678, 4'hF, k == 3, 0, 0);
            #1;
            check_output("stall_dram_ready", dram_ready, k == 3);
            check_output("stall_iram_ready", iram_ready, 1'b0);
            check_output("stall_bus_write", bus_write, 1'b1);
            cycle();
        end
        apply_stimulus(1, 32'h104, 0, 0, 0, 0, 0, 1, 0, 0);
        #1;
        check_output("after_stall_iram", iram_ready, 1'b1);
        cycle();
        idle(1, 32'h77);
        cycle();

        // Two fetches fill the FIFO; a dram read is blocked but a store goes through.
        apply_stimulus(1, 32'h300, 0, 0, 0, 0, 0, 1, 0, 0);
        cycle();
        apply_stimulus(1, 32'h304, 0, 0, 0, 0, 0, 1, 0, 0);
        cycle();
        apply_stimulus(0, 0, 1, 0, 32'h900, 0, 0, 1, 0, 0);
        #1;
        check_output("full_read_blocked", dram_ready, 1'b0);
        cycle();
        apply_stimulus(0, 0, 1, 1, 32'h904, 32'hCAFE, 4'h3, 1, 0, 0);
        #1;
        check_output("full_store_ok", dram_ready, 1'b1);
        cycle();
        idle(1, 32'hA1);
        #1;
        check_output("full_resp1", iram_rvalid, 1'b1);
        cycle();
        idle(1, 32'hA2);
        #1;
        check_output("full_resp2", iram_rvalid, 1'b1);
        cycle();

        // Interleaved iram, dram, iram reads return A, B, C to their owners.
        apply_stimulus(1, 32'h500, 0, 0, 0, 0, 0, 1, 0, 0);
        cycle();
        apply_stimulus(0, 0, 1, 0, 32'h600, 0, 0, 1, 1, 32'hA);
        #1;
        check_output("route_A", iram_rvalid, 1'b1);
        cycle();
        apply_stimulus(1, 32'h504, 0, 0, 0, 0, 0, 1, 1, 32'hB);
        #1;
        check_output("route_B", dram_rvalid, 1'b1);
        cycle();
        idle(1, 32'hC);
        #1;
        check_output("route_C", iram_rvalid, 1'b1);
        cycle();

        // Response with nothing outstanding, and a late response after a reset.
        idle(1, 32'hBAD);
        #1;
        check_output("orphan_no_rvalid", iram_rvalid | dram_rvalid, 1'b0);
        cycle();
        idle(0, 0);
        #1;
        check_output("orphan_err", arb_err, 1'b1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        #1;
        check_output("err_cleared", arb_err, 1'b0);
        apply_stimulus(1, 32'h700, 0, 0, 0, 0, 0, 1, 0, 0);
        cycle();
        rst = 1'b1;
        idle(0, 0);
        cycle();
        rst = 1'b0;
        idle(1, 32'hBEEF);
        #1;
        check_output("late_no_rvalid", iram_rvalid | dram_rvalid, 1'b0);
        cycle();
        idle(0, 0);
        #1;
        check_output("late_err", arb_err, 1'b1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;

        // Randomized traffic; requests are held until the model sees them accepted.
        ipend = 1'b0;
        dpend = 1'b0;
        ia = 0; da = 0; wd = 0; ws = 0; dw = 0;
        for (int n = 0; n < 800; n++) begin
            if (!ipend && ($urandom % 2 == 0)) begin
                ipend = 1'b1;
                ia    = $urandom;
            end
            if (!dpend && ($urandom % 2 == 0)) begin
                dpend = 1'b1;
                dw    = ($urandom % 3 == 0);
                da    = $urandom;
                wd    = $urandom;
                ws    = 4'($urandom);
            end
            rst = ($urandom % 100 == 0);
            apply_stimulus(ipend, ia, dpend, dw, da, wd, ws, ($urandom % 5) < 3,
                           (owners.size() > 0) ? ($urandom % 2 == 0) : ($urandom % 50 == 0),
                           $urandom);
            cycle();
            if (last_acc && !last_win) ipend = 1'b0;
            if (last_acc && last_win)  dpend = 1'b0;
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
